control: RTL and testbench

- Instruction-sequencing controller for the VeriRISC CPU.
- Steps a fixed 8-phase instruction cycle and decodes the current opcode (opcode_t from typedefs) plus the ALU zero flag into the one-hot-ish strobes that drive the memory, IR, PC, accumulator and ALU.
- Sits between the instruction register / ALU and the rest of the datapath.
- One instruction completes every 8 clocks.

---
 rtl/control.sv | 127 ++++++++++++
 tb/tb_control.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : control                                                      |
// | Description : VeriRISC 8-phase instruction sequencer and strobe decoder.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+

package typedefs;
  typedef enum logic [2:0] {
    HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3,
    XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0, INST_FETCH = 3'd1, INST_LOAD = 3'd2, IDLE  = 3'd3,
    OP_ADDR    = 3'd4, OP_FETCH   = 3'd5, ALU_OP    = 3'd6, STORE = 3'd7
  } state_t;
endpackage

module control
  import typedefs::*;
#(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic    clk,
  input  logic    rst_,
  input  opcode_t opcode,
  input  logic    zero,
  output logic    mem_rd,
  output logic    load_ir,
  output logic    halt,
  output logic    inc_pc,
  output logic    load_ac,
  output logic    load_pc,
  output logic    mem_wr
);

  state_t r_state;
  state_t w_next_state;
  logic   r_halted;
  logic   w_halt_now;
  logic   w_aluop;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state  <= INST_ADDR;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_halted <= r_halted | w_halt_now;
    end
  end

  always_comb begin
    w_next_state = INST_ADDR;
    w_halt_now   = 1'b0;
    mem_rd       = 1'b0;
    load_ir      = 1'b0;
    halt         = 1'b0;
    inc_pc       = 1'b0;
    load_ac      = 1'b0;
    load_pc      = 1'b0;
    mem_wr       = 1'b0;
    w_aluop      = (opcode == ADD) || (opcode == AND) ||
                   (opcode == XOR) || (opcode == LDA);

    if (r_halted) begin
      // Frozen in OP_ADDR: only halt is driven so the PC cannot advance.
      w_next_state = OP_ADDR;
      halt         = 1'b1;
    end else begin
      case (r_state)
        INST_ADDR: begin
          w_next_state = INST_FETCH;
        end
        INST_FETCH: begin
          w_next_state = INST_LOAD;
          mem_rd       = 1'b1;
        end
        INST_LOAD: begin
          w_next_state = IDLE;
          mem_rd       = 1'b1;
          load_ir      = 1'b1;
        end
        IDLE: begin
          w_next_state = OP_ADDR;
          mem_rd       = 1'b1;
          load_ir      = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == HLT);
          if (HALT_STICKY && (opcode == HLT)) begin
            w_next_state = OP_ADDR;
            w_halt_now   = 1'b1;
          end else begin
            w_next_state = OP_FETCH;
          end
        end
        OP_FETCH: begin
          w_next_state = ALU_OP;
          mem_rd       = w_aluop;
        end
        ALU_OP: begin
          w_next_state = STORE;
          mem_rd       = w_aluop;
          load_ac      = w_aluop;
          inc_pc       = (opcode == SKZ) && zero;
          load_pc      = (opcode == JMP);
        end
        STORE: begin
          w_next_state = INST_ADDR;
          mem_rd       = w_aluop;
          load_ac      = w_aluop;
          inc_pc       = (opcode == JMP);
          load_pc      = (opcode == JMP);
          mem_wr       = (opcode == STO);
        end
        default: begin
          w_next_state = INST_ADDR;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_control                                                   |
// | Description : Model-checked bench for control, sticky and pulsed halt.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+

module tb_control;
  import typedefs::*;

  logic    clk  = 1'b0;
  logic    rst_ = 1'b0;
  opcode_t opcode = ADD;
  logic    zero = 1'b0;

  // Packed as {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}
  logic [6:0] out_s;
  logic [6:0] out_n;

  int checks = 0;
  int errors = 0;

  int ph_s = 0;
  int ph_n = 0;
  bit hl_s = 1'b0;

  always #5 clk = ~clk;

  control #(.HALT_STICKY(1'b1)) dut_s (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero),
    .mem_rd(out_s[6]), .load_ir(out_s[5]), .halt(out_s[4]), .inc_pc(out_s[3]),
    .load_ac(out_s[2]), .load_pc(out_s[1]), .mem_wr(out_s[0])
  );

  control #(.HALT_STICKY(1'b0)) dut_n (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero),
    .mem_rd(out_n[6]), .load_ir(out_n[5]), .halt(out_n[4]), .inc_pc(out_n[3]),
    .load_ac(out_n[2]), .load_pc(out_n[1]), .mem_wr(out_n[0])
  );

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Expected strobes from the phase number, written as phase-set membership.
  function automatic logic [6:0] model_out(input int ph, input bit halted,
                                           input opcode_t op, input logic z);
    bit aluop;
    bit rd, ir, h, inc, ac, pc, wr;
    if (halted) return 7'b0010000;
    aluop = op inside {ADD, AND, XOR, LDA};
    rd  = (ph inside {[1:3]}) || ((ph inside {[5:7]}) && aluop);
    ir  = ph inside {2, 3};
    h   = (ph == 4) && (op == HLT);
    inc = (ph == 4) || ((ph == 6) && (op == SKZ) && (z == 1'b1)) ||
          ((ph == 7) && (op == JMP));
    ac  = (ph inside {6, 7}) && aluop;
    pc  = (ph inside {6, 7}) && (op == JMP);
    wr  = (ph == 7) && (op == STO);
    return {rd, ir, h, inc, ac, pc, wr};
  endfunction

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ph_s = 0;
      hl_s = 1'b0;
      ph_n = 0;
    end else begin
      if (!hl_s) begin
        if ((ph_s == 4) && (opcode == HLT)) hl_s = 1'b1;
        else ph_s = (ph_s + 1) % 8;
      end
      ph_n = (ph_n + 1) % 8;
    end
  end

  always @(negedge clk) begin
    check("cyc_sticky", out_s, model_out(ph_s, hl_s, opcode, zero));
    check("cyc_pulsed", out_n, model_out(ph_n, 1'b0, opcode, zero));
    check("rd_wr_excl", {5'b0, out_s[6] & out_s[0], out_n[6] & out_n[0]}, 7'b0);
  end

  task automatic run_from_reset(input opcode_t op, input logic z);
    @(negedge clk);
    #1 rst_ = 1'b0;
    opcode = op;
    zero   = z;
    @(negedge clk);
    #1 rst_ = 1'b1;
  endtask

  task automatic pin(input string name, input opcode_t op, input logic z,
                     input logic [6:0] exp [8]);
    run_from_reset(op, z);
    for (int p = 0; p < 8; p++) begin
      if (p > 0) @(negedge clk);
      check($sformatf("%s_dut_p%0d", name, p), out_n, exp[p]);
      check($sformatf("%s_model_p%0d", name, p), model_out(p, 1'b0, op, z), exp[p]);
    end
  endtask

  logic [6:0] add_exp  [8] = '{7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                               7'b0001000, 7'b1000000, 7'b1000100, 7'b1000100};
  logic [6:0] jmp_exp  [8] = '{7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                               7'b0001000, 7'b0000000, 7'b0000010, 7'b0001010};
  logic [6:0] sto_exp  [8] = '{7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                               7'b0001000, 7'b0000000, 7'b0000000, 7'b0000001};
  logic [6:0] skz1_exp [8] = '{7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                               7'b0001000, 7'b0000000, 7'b0001000, 7'b0000000};
  logic [6:0] skz0_exp [8] = '{7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                               7'b0001000, 7'b0000000, 7'b0000000, 7'b0000000};

  initial begin
    repeat (2) @(negedge clk);
    #1 rst_ = 1'b1;
    check("reset_state", out_s | out_n, 7'b0);

    pin("add", ADD, 1'b0, add_exp);
    pin("jmp", JMP, 1'b1, jmp_exp);
    pin("sto", STO, 1'b0, sto_exp);
    pin("skz_z1", SKZ, 1'b1, skz1_exp);
    pin("skz_z0", SKZ, 1'b0, skz0_exp);

    // Asynchronous reset while in ALU_OP
    run_from_reset(ADD, 1'b0);
    repeat (6) @(negedge clk);
    check("pre_rst_aluop", out_n, 7'b1000100);
    #2 rst_ = 1'b0;
    #1 check("async_rst_s", out_s, 7'b0);
    check("async_rst_n", out_n, 7'b0);
    @(negedge clk);
    #1 rst_ = 1'b1;
    @(negedge clk);
    check("post_rst_fetch", out_n, 7'b1000000);

    // Sticky halt holds across opcode changes; pulsed halt lasts one cycle
    run_from_reset(HLT, 1'b0);
    repeat (4) @(negedge clk);
    check("hlt_first_s", out_s, 7'b0011000);
    check("hlt_first_n", out_n, 7'b0011000);
    @(negedge clk);
    check("hlt_pulse_end_n", out_n, 7'b0000000);
    check("hlt_held_s", out_s, 7'b0010000);
    repeat (3) @(negedge clk);
    check("hlt_next_inst_addr_n", out_n, 7'b0000000);
    @(negedge clk);
    check("hlt_next_fetch_n", out_n, 7'b1000000);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      check($sformatf("hlt_hold_%0d", i), out_s, 7'b0010000);
      if (i == 3) #1 opcode = ADD;
    end
    #1 rst_ = 1'b0;
    #1 check("hlt_cleared", out_s, 7'b0);
    @(negedge clk);
    #1 rst_ = 1'b1;
    repeat (4) @(negedge clk);
    check("hlt_resumed_s", out_s, 7'b0001000);

    // Randomised opcodes, zero flag and reset pulses
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      #1;
      zero = 1'($urandom);
      if (rst_ == 1'b0) rst_ = 1'b1;
      else if ($urandom_range(0, 59) == 0) rst_ = 1'b0;
      if (ph_n == 0) opcode = opcode_t'($urandom_range(0, 7));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
